// File: rtl/byte_serial_ctrl.sv
// Byte-to-serial frame controller: latches a byte, walks an external bit-select
// mux LSB first, optionally appends an even-parity slot, then pulses done.
module byte_serial_ctrl #(
  parameter int unsigned CLK_DIV   = 4,
  parameter bit          PARITY_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] Data_in,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] Data_hold,
  output logic [2:0] bit_n,
  input  logic       sel_bit,
  output logic       ser_out,
  output logic       bit_strobe,
  output logic       busy,
  output logic       done
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_e;

  state_e             state_q;
  logic [7:0]         data_hold_q;
  logic [2:0]         bit_n_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               par_q;
  logic               in_ready_q;
  logic               busy_q;
  logic               done_q;
  logic               strobe_q;
  logic               last_slot;
  logic               ser_d;

  assign last_slot = (cnt_q == CNT_W'(CLK_DIV - 1));

  // NOTE: every register here is updated with <= so all state moves together on
  // the edge; a blocking assignment would let later lines see half-updated state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      data_hold_q <= 8'h00;
      bit_n_q     <= 3'd0;
      cnt_q       <= '0;
      par_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      strobe_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid && in_ready_q) begin
            data_hold_q <= Data_in;
            bit_n_q     <= 3'd0;
            cnt_q       <= '0;
            par_q       <= 1'b0;
            in_ready_q  <= 1'b0;
            busy_q      <= 1'b1;
            strobe_q    <= 1'b1;
            state_q     <= DATA;
          end
        end
        DATA: begin
          if (strobe_q) begin
            par_q <= par_q ^ sel_bit;
          end
          if (last_slot) begin
            cnt_q <= '0;
            if (bit_n_q == 3'd7) begin
              if (PARITY_EN) begin
                strobe_q <= 1'b1;
                state_q  <= PARITY;
              end else begin
                strobe_q <= 1'b0;
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                state_q  <= DONE;
              end
            end else begin
              bit_n_q  <= bit_n_q + 3'd1;
              strobe_q <= 1'b1;
            end
          end else begin
            cnt_q    <= cnt_q + CNT_W'(1);
            strobe_q <= 1'b0;
          end
        end
        PARITY: begin
          if (last_slot) begin
            cnt_q    <= '0;
            strobe_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= DONE;
          end else begin
            cnt_q    <= cnt_q + CNT_W'(1);
            strobe_q <= 1'b0;
          end
        end
        DONE: begin
          done_q     <= 1'b0;
          in_ready_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // The mux return path goes straight to the line so the bit appears in its own slot.
  always_comb begin
    ser_d = 1'b0;
    case (state_q)
      DATA:    ser_d = sel_bit;
      PARITY:  ser_d = par_q;
      default: ser_d = 1'b0;
    endcase
  end

  assign ser_out    = ser_d;
  assign in_ready   = in_ready_q;
  assign Data_hold  = data_hold_q;
  assign bit_n      = bit_n_q;
  assign bit_strobe = strobe_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_byte_serial_ctrl.sv
// Bench for byte_serial_ctrl: a CLK_DIV=4 parity instance walked frame by frame
// against a cycle timeline and slot scoreboard, plus a CLK_DIV=1 no-parity instance.
module tb_byte_serial_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst, a_in_valid, a_in_ready, a_sel_bit, a_ser_out, a_bit_strobe, a_busy, a_done;
  logic [7:0] a_data_in, a_data_hold;
  logic [2:0] a_bit_n;

  logic       b_rst, b_in_valid, b_in_ready, b_sel_bit, b_ser_out, b_bit_strobe, b_busy, b_done;
  logic [7:0] b_data_in, b_data_hold;
  logic [2:0] b_bit_n;

  // External bit-select muxes closing the return path.
  assign a_sel_bit = a_data_hold[a_bit_n];
  assign b_sel_bit = b_data_hold[b_bit_n];

  byte_serial_ctrl #(.CLK_DIV(4), .PARITY_EN(1'b1)) u_dut_a (
    .clk(clk), .rst(a_rst), .Data_in(a_data_in), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .Data_hold(a_data_hold), .bit_n(a_bit_n),
    .sel_bit(a_sel_bit), .ser_out(a_ser_out), .bit_strobe(a_bit_strobe),
    .busy(a_busy), .done(a_done)
  );

  byte_serial_ctrl #(.CLK_DIV(1), .PARITY_EN(1'b0)) u_dut_b (
    .clk(clk), .rst(b_rst), .Data_in(b_data_in), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .Data_hold(b_data_hold), .bit_n(b_bit_n),
    .sel_bit(b_sel_bit), .ser_out(b_ser_out), .bit_strobe(b_bit_strobe),
    .busy(b_busy), .done(b_done)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end else begin
      pass_cnt++;
    end
  endtask

  // Scoreboard of expected slot values for instance A, popped on each bit_strobe.
  logic sb_q[$];
  logic sb_exp;

  always @(negedge clk) begin
    if (a_bit_strobe) begin
      check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
      if (sb_q.size() > 0) begin
        sb_exp = sb_q.pop_front();
        check("sb_slot", 32'(a_ser_out), 32'(sb_exp));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check_a_reset(input string tag);
    check({tag, "_in_ready"},  32'(a_in_ready),   32'd1);
    check({tag, "_data_hold"}, 32'(a_data_hold),  32'h00);
    check({tag, "_bit_n"},     32'(a_bit_n),      32'd0);
    check({tag, "_ser_out"},   32'(a_ser_out),    32'd0);
    check({tag, "_strobe"},    32'(a_bit_strobe), 32'd0);
    check({tag, "_busy"},      32'(a_busy),       32'd0);
    check({tag, "_done"},      32'(a_done),       32'd0);
  endtask

  // Entered #1 into cycle 1 after the handshake; returns at the negedge of cycle 38.
  task automatic check_frame(input logic [7:0] data, input logic par, input int poke, input bit keep);
    logic       e_ser, e_strobe, e_busy, e_done;
    logic [2:0] e_bitn;
    logic [2:0] slot;
    if (!keep) begin
      a_in_valid = 1'b0;
      a_data_in  = ~data;
    end
    for (int c = 1; c <= 37; c++) begin
      if (poke != 0 && c == poke) begin
        a_in_valid = 1'b1;
        a_data_in  = 8'h3C;
      end else if (poke != 0 && c == poke + 1) begin
        a_in_valid = 1'b0;
        a_data_in  = ~data;
      end
      @(negedge clk);
      if (c <= 32) begin
        slot     = 3'((c - 1) / 4);
        e_ser    = data[slot];
        e_strobe = ((c - 1) % 4 == 0);
        e_busy   = 1'b1;
        e_done   = 1'b0;
        e_bitn   = slot;
      end else if (c <= 36) begin
        e_ser    = par;
        e_strobe = (c == 33);
        e_busy   = 1'b1;
        e_done   = 1'b0;
        e_bitn   = 3'd7;
      end else begin
        e_ser    = 1'b0;
        e_strobe = 1'b0;
        e_busy   = 1'b0;
        e_done   = 1'b1;
        e_bitn   = 3'd7;
      end
      check("a_ser_out",   32'(a_ser_out),    32'(e_ser));
      check("a_strobe",    32'(a_bit_strobe), 32'(e_strobe));
      check("a_busy",      32'(a_busy),       32'(e_busy));
      check("a_done",      32'(a_done),       32'(e_done));
      check("a_bit_n",     32'(a_bit_n),      32'(e_bitn));
      check("a_in_ready",  32'(a_in_ready),   32'd0);
      check("a_data_hold", 32'(a_data_hold),  32'(data));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("a_idle_ready", 32'(a_in_ready), 32'd1);
    check("a_idle_busy",  32'(a_busy),     32'd0);
    check("a_idle_done",  32'(a_done),     32'd0);
  endtask

  task automatic send_a(input logic [7:0] data, input logic par, input int poke, input bit keep);
    a_in_valid = 1'b1;
    a_data_in  = data;
    for (int i = 0; i < 8; i++) sb_q.push_back(data[i]);
    sb_q.push_back(par);
    @(posedge clk);
    #1;
    check_frame(data, par, poke, keep);
    if (!keep) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_b(input logic [7:0] data);
    b_in_valid = 1'b1;
    b_data_in  = data;
    @(posedge clk);
    #1;
    b_in_valid = 1'b0;
    b_data_in  = ~data;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (c <= 8) begin
        check("b_ser_out", 32'(b_ser_out),    32'(data[3'(c - 1)]));
        check("b_strobe",  32'(b_bit_strobe), 32'd1);
        check("b_busy",    32'(b_busy),       32'd1);
        check("b_bit_n",   32'(b_bit_n),      32'(c - 1));
        check("b_done",    32'(b_done),       32'd0);
      end else if (c == 9) begin
        check("b_done_ser",    32'(b_ser_out),    32'd0);
        check("b_done_strobe", 32'(b_bit_strobe), 32'd0);
        check("b_done_busy",   32'(b_busy),       32'd0);
        check("b_done_pulse",  32'(b_done),       32'd1);
        check("b_done_bit_n",  32'(b_bit_n),      32'd7);
      end else begin
        check("b_idle_ready", 32'(b_in_ready), 32'd1);
        check("b_idle_done",  32'(b_done),     32'd0);
      end
      @(posedge clk);
      #1;
    end
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
    int         poke;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{data: 8'hA5, par: 1'b0, poke: 10};
    vecs[1] = '{data: 8'h07, par: 1'b1, poke: 0};
    vecs[2] = '{data: 8'h00, par: 1'b0, poke: 0};
    vecs[3] = '{data: 8'hFF, par: 1'b0, poke: 0};
    vecs[4] = '{data: 8'h6E, par: 1'b1, poke: 0};

    a_rst = 1'b1; a_in_valid = 1'b0; a_data_in = 8'h00;
    b_rst = 1'b1; b_in_valid = 1'b0; b_data_in = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    a_rst = 1'b0;
    b_rst = 1'b0;
    @(negedge clk);
    check_a_reset("rst");
    check("b_rst_ready", 32'(b_in_ready), 32'd1);
    check("b_rst_busy",  32'(b_busy),     32'd0);
    @(posedge clk);
    #1;

    for (int v = 0; v < 5; v++) send_a(vecs[v].data, vecs[v].par, vecs[v].poke, 1'b0);

    // Back-to-back frames with in_valid held high.
    send_a(8'hC3, 1'b0, 0, 1'b1);
    send_a(8'hC3, 1'b0, 0, 1'b0);

    // Abort mid-frame at cycle 15.
    a_in_valid = 1'b1;
    a_data_in  = 8'hA5;
    for (int i = 0; i < 8; i++) sb_q.push_back(a_data_in[i]);
    sb_q.push_back(1'b0);
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    @(negedge clk);
    check("abort_busy_before", 32'(a_busy), 32'd1);
    a_rst = 1'b1;
    @(posedge clk);
    #1;
    a_rst = 1'b0;
    sb_q.delete();
    @(negedge clk);
    check_a_reset("abort");
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      check("abort_no_done", 32'(a_done), 32'd0);
      check("abort_no_busy", 32'(a_busy), 32'd0);
    end
    @(posedge clk);
    #1;
    send_a(8'h81, 1'b0, 0, 1'b0);

    // Reset wins over a simultaneous handshake.
    a_rst      = 1'b1;
    a_in_valid = 1'b1;
    a_data_in  = 8'h5A;
    @(posedge clk);
    #1;
    a_rst      = 1'b0;
    a_in_valid = 1'b0;
    @(negedge clk);
    check_a_reset("rst_hs");
    @(negedge clk);
    check("rst_hs_still_idle", 32'(a_busy), 32'd0);
    @(posedge clk);
    #1;

    send_b(8'hFF);
    send_b(8'h96);
    send_b(8'h01);

    check("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/byte_serial_ctrl.md
BYTE_SERIAL_CTRL -- requirements
Module: byte_serial_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clock cycles per serial bit slot; legal range 1..256.
REQ-002 SHALL have parameter PARITY_EN, default 1: 1 appends an even-parity slot after bit 7; 0 omits it.
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port Data_in  input  8  byte offered for serialization.
REQ-006 SHALL have port in_valid  input  1  Data_in valid.
REQ-007 SHALL have port in_ready  output  1  block can accept a byte.
REQ-008 SHALL have port Data_hold  output  8  latched byte; drives the external bit-select mux data input.
REQ-009 SHALL have port bit_n  output  3  bit index; drives the external bit-select mux select input.
REQ-010 SHALL have port sel_bit  input  1  external mux output, Data_hold[bit_n], combinational return path.
REQ-011 SHALL have port ser_out  output  1  serial line output.
REQ-012 SHALL have port bit_strobe  output  1  one-cycle pulse on the first cycle of every data or parity slot.
REQ-013 SHALL have port busy  output  1  frame in progress.
REQ-014 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-015 SHALL implement FSM states IDLE, DATA, PARITY, DONE.
REQ-016 SHALL assert in_ready only in IDLE; handshake = in_valid && in_ready sampled at a rising edge.
REQ-017 On handshake, SHALL latch Data_in into Data_hold, set bit_n=0, clear the slot counter and parity accumulator, and enter DATA on the next cycle.
REQ-018 In DATA, SHALL hold each bit_n value for exactly CLK_DIV cycles, incrementing bit_n 0->7 (LSB first).
REQ-019 In DATA, SHALL drive ser_out = sel_bit in the same cycle (no register between sel_bit and ser_out).
REQ-020 SHALL XOR sel_bit into the parity accumulator on each bit_strobe cycle of DATA.
REQ-021 After the last cycle of bit 7, SHALL enter PARITY if PARITY_EN=1, else DONE.
REQ-022 In PARITY, SHALL drive ser_out = accumulated even parity for CLK_DIV cycles, then enter DONE.
REQ-023 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-024 SHALL drive ser_out=0 and bit_strobe=0 in IDLE and DONE.
REQ-025 busy SHALL be 1 in DATA and PARITY, 0 in IDLE and DONE.
REQ-026 Handshake at cycle 0 SHALL put DATA in cycles 1..8*CLK_DIV, PARITY (if enabled) in the next CLK_DIV cycles, DONE in the next single cycle, and in_ready=1 in the following cycle.
REQ-027 in_valid while not in IDLE SHALL be ignored; it SHALL NOT alter Data_hold or the frame.
REQ-028 Changes on Data_in after the handshake SHALL NOT affect the current frame.
REQ-029 With CLK_DIV=1, bit_strobe SHALL be high on every DATA/PARITY cycle.
REQ-030 bit_n SHALL hold 7 during PARITY and DONE, and SHALL never wrap to 0 within a frame.

Reset
REQ-031 With rst=1 at a rising edge, SHALL force on the next cycle: state IDLE, in_ready=1, Data_hold=8'h00, bit_n=0, ser_out=0, bit_strobe=0, busy=0, done=0, slot counter and parity accumulator 0.
REQ-032 rst SHALL override a simultaneous handshake and abort any frame in progress without emitting done.

Verification
REQ-033 CLK_DIV=4, PARITY_EN=1, Data_in=8'hA5 accepted at cycle 0 -> ser_out = 1,0,1,0,0,1,0,1 (4 cycles each, cycles 1-32); parity 0 (cycles 33-36); done=1 at cycle 37; in_ready=1 at cycle 38.
REQ-034 CLK_DIV=4, PARITY_EN=1, Data_in=8'h07 -> parity slot ser_out=1; bit_strobe pulses at cycles 1,5,...,33 (9 pulses).
REQ-035 CLK_DIV=1, PARITY_EN=0, Data_in=8'hFF -> ser_out=1 for cycles 1-8, done at cycle 9, no parity slot.
REQ-036 in_valid=1 with Data_in=8'h3C at cycle 10 of an 8'hA5 frame -> in_ready=0, frame bits unchanged, Data_hold stays 8'hA5.
REQ-037 rst=1 at cycle 15 of a frame -> next cycle all outputs at reset values, no done pulse; new byte 8'h81 accepted afterwards serializes correctly.
REQ-038 in_valid held high continuously -> frames separated by exactly one DONE cycle and one IDLE cycle.
